// File: rtl/ft64_pack_pkg.sv
// ft64_pack_pkg: shared constants and types for the FT64 instruction packer.
//   OP_CMPRSSD     - FT64 major opcode of the compressed-instruction escape
//   LEN2/LEN4/LEN6 - instruction byte lengths
//   len_code_e     - ins[7:6] length code
//   code_to_len    - length code to byte length
package ft64_pack_pkg;

   localparam logic [5:0] OP_CMPRSSD = 6'h2F;

   localparam logic [2:0] LEN2 = 3'd2;
   localparam logic [2:0] LEN4 = 3'd4;
   localparam logic [2:0] LEN6 = 3'd6;

   typedef enum logic [1:0] {
      LcLen4  = 2'b00,
      LcLen6  = 2'b01,
      LcLen2a = 2'b10,
      LcLen2b = 2'b11
   } len_code_e;

   function automatic logic [2:0] code_to_len(input len_code_e code);
      logic [2:0] len;
      unique case (code)
         LcLen4:  len = LEN4;
         LcLen6:  len = LEN6;
         default: len = LEN2;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/ft64_ins_packer_if.sv
// ft64_ins_packer_if: instruction-in and memory-write-out handshake bundle.
//   ins_v/ins_rdy/ins              - one instruction per handshake
//   wr_v/wr_rdy/wr_adr/wr_dat/wr_sel - 64-bit instruction-memory write word
// Modports:
//   master - the packer (drives ins_rdy and the write word)
//   slave  - the environment (supplies instructions, accepts write words)
interface ft64_ins_packer_if #(
   parameter int unsigned ADDR_W = 32
);

   logic              ins_v;
   logic              ins_rdy;
   logic [47:0]       ins;
   logic              wr_v;
   logic              wr_rdy;
   logic [ADDR_W-1:0] wr_adr;
   logic [63:0]       wr_dat;
   logic [7:0]        wr_sel;

   modport master (
      input  ins_v, ins, wr_rdy,
      output ins_rdy, wr_v, wr_adr, wr_dat, wr_sel
   );

   modport slave (
      output ins_v, ins, wr_rdy,
      input  ins_rdy, wr_v, wr_adr, wr_dat, wr_sel
   );

endinterface

// File: rtl/ft64_pack_len.sv
// ft64_pack_len: combinational FT64 instruction length decode.
//   ins - instruction, byte 0 in ins[7:0]
//   len - byte length (2, 4 or 6)
// Build option FT64_PACK_DCI_EN: opcode OP_CMPRSSD always decodes as a
// 2-byte instruction regardless of ins[7:6].
module ft64_pack_len
   import ft64_pack_pkg::*;
(
   input  logic [47:0] ins,
   output logic [2:0]  len
);

   logic unused_ins_hi;
   assign unused_ins_hi = ^ins[47:8];

   always_comb begin
      len = code_to_len(len_code_e'(ins[7:6]));
`ifdef FT64_PACK_DCI_EN
      if (ins[5:0] == OP_CMPRSSD) begin
         len = LEN2;
      end
`else
      len = len | 3'(ins[5:0] & 6'h0);
`endif
   end

endmodule

// File: rtl/ft64_ins_packer.sv
// ft64_ins_packer: packs variable-length FT64 instructions little-endian into
// 64-bit instruction-memory write words with byte selects.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   bus       - instruction handshake in, memory write word out (master modport)
//   ld_adr    - load write pointer from start_adr (only when idle and empty)
//   start_adr - new byte address, bit 0 ignored
//   flush     - emit the partially filled low word
//   pc_o      - byte address the next accepted instruction will occupy
// Build option FT64_PACK_DCI_EN is handled in ft64_pack_len.
module ft64_ins_packer
   import ft64_pack_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   ft64_ins_packer_if.master bus,
   input  logic              ld_adr,
   input  logic [ADDR_W-1:0] start_adr,
   input  logic              flush,
   output logic [ADDR_W-1:0] pc_o
);

   // Staging buffer: byte i of the current word lives at stg[i]; bytes 8..15
   // only hold spill-over until the low word is emitted.
   logic [15:0][7:0]  stg_q, stg_d;
   logic [15:0]       mask_q, mask_d;
   logic [3:0]        fp_q, fp_d;
   logic [ADDR_W-1:0] wa_q, wa_d;

   logic              wr_v_q, wr_v_d;
   logic [ADDR_W-1:0] wr_adr_q, wr_adr_d;
   logic [63:0]       wr_dat_q, wr_dat_d;
   logic [7:0]        wr_sel_q, wr_sel_d;

   logic [2:0] len;
   logic       out_free;
   logic       ins_rdy;
   logic       acc;
   logic [4:0] fp_sum;
   logic       unused_start_lsb;

   assign unused_start_lsb = start_adr[0];

   ft64_pack_len u_len (
      .ins (bus.ins),
      .len (len)
   );

   assign out_free = !wr_v_q || bus.wr_rdy;
   assign ins_rdy  = !ld_adr && out_free;
   assign acc      = bus.ins_v && ins_rdy;
   assign fp_sum   = {1'b0, fp_q} + {2'b00, len};

   always_comb begin
      stg_d    = stg_q;
      mask_d   = mask_q;
      fp_d     = fp_q;
      wa_d     = wa_q;
      // A pending word leaves when the memory takes it; a newly formed word
      // below may reload the register on the same edge.
      wr_v_d   = wr_v_q && !bus.wr_rdy;
      wr_adr_d = wr_adr_q;
      wr_dat_d = wr_dat_q;
      wr_sel_d = wr_sel_q;

      if (acc) begin
         for (int i = 0; i < 6; i++) begin
            if (3'(i) < len) begin
               stg_d[fp_q + 4'(i)]  = bus.ins[8*i +: 8];
               mask_d[fp_q + 4'(i)] = 1'b1;
            end
         end
         if (fp_sum >= 5'd8) begin
            wr_v_d   = 1'b1;
            wr_adr_d = wa_q;
            wr_dat_d = stg_d[7:0];
            wr_sel_d = mask_d[7:0];
            stg_d    = {64'h0, stg_d[15:8]};
            mask_d   = {8'h00, mask_d[15:8]};
            fp_d     = 4'(fp_sum - 5'd8);
            wa_d     = wa_q + ADDR_W'(8);
         end else begin
            fp_d = fp_sum[3:0];
         end
      end else if (flush && out_free && (mask_q[7:0] != 8'h00)) begin
         // Partial word out; fp/wa stay so later bytes land in the same word.
         wr_v_d   = 1'b1;
         wr_adr_d = wa_q;
         wr_dat_d = stg_q[7:0];
         wr_sel_d = mask_q[7:0];
         mask_d   = '0;
      end else if (ld_adr && (mask_q == 16'h0000) && !wr_v_q) begin
         wa_d = {start_adr[ADDR_W-1:3], 3'b000};
         fp_d = {1'b0, start_adr[2:1], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stg_q    <= '0;
         mask_q   <= '0;
         fp_q     <= '0;
         wa_q     <= '0;
         wr_v_q   <= 1'b0;
         wr_adr_q <= '0;
         wr_dat_q <= '0;
         wr_sel_q <= '0;
      end else begin
         stg_q    <= stg_d;
         mask_q   <= mask_d;
         fp_q     <= fp_d;
         wa_q     <= wa_d;
         wr_v_q   <= wr_v_d;
         wr_adr_q <= wr_adr_d;
         wr_dat_q <= wr_dat_d;
         wr_sel_q <= wr_sel_d;
      end
   end

   assign bus.ins_rdy = ins_rdy;
   assign bus.wr_v    = wr_v_q;
   assign bus.wr_adr  = wr_adr_q;
   assign bus.wr_dat  = wr_dat_q;
   assign bus.wr_sel  = wr_sel_q;
   assign pc_o        = wa_q + ADDR_W'(fp_q);

endmodule

// File: tb/tb_ft64_ins_packer.sv
// tb_ft64_ins_packer: directed self-checking bench for ft64_ins_packer.
module tb_ft64_ins_packer;
   import ft64_pack_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_adr;
   logic        flush;
   logic [31:0] start_adr;
   logic [31:0] pc_o;

   int checks = 0;
   int errors = 0;

   ft64_ins_packer_if #(.ADDR_W(32)) bus ();

   ft64_ins_packer #(.ADDR_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .ld_adr    (ld_adr),
      .start_adr (start_adr),
      .flush     (flush),
      .pc_o      (pc_o)
   );

   always #5 clk = ~clk;

   // Words accepted by memory, plus a byte image built from them.
   logic [31:0] q_adr[$];
   logic [63:0] q_dat[$];
   logic [7:0]  q_sel[$];
   logic [7:0]  mem[int unsigned];

   always @(posedge clk) begin
      if (!rst && bus.wr_v && bus.wr_rdy) begin
         q_adr.push_back(bus.wr_adr);
         q_dat.push_back(bus.wr_dat);
         q_sel.push_back(bus.wr_sel);
         for (int b = 0; b < 8; b++) begin
            if (bus.wr_sel[b]) mem[bus.wr_adr + 32'(b)] = bus.wr_dat[8*b +: 8];
         end
      end
   end

   function automatic int len_of(input logic [7:0] b0);
`ifdef FT64_PACK_DCI_EN
      if (b0[5:0] == OP_CMPRSSD) return 2;
`endif
      case (b0[7:6])
         2'b00:   return 4;
         2'b01:   return 6;
         default: return 2;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      q_adr.delete();
      q_dat.delete();
      q_sel.delete();
   endtask

   task automatic load(input logic [31:0] a);
      ld_adr    = 1'b1;
      start_adr = a;
      step();
      ld_adr    = 1'b0;
   endtask

   // Present one instruction until accepted; rnd randomises wr_rdy each cycle.
   task automatic send(input logic [47:0] v, input bit rnd);
      int n = 0;
      bus.ins_v = 1'b1;
      bus.ins   = v;
      if (rnd) bus.wr_rdy = 1'($urandom_range(0, 1));
      #1;
      while (!bus.ins_rdy && n < 50) begin
         step();
         if (rnd) bus.wr_rdy = 1'($urandom_range(0, 1));
         #1;
         n++;
      end
      checks++;
      if (!bus.ins_rdy) begin
         errors++;
         $display("FAIL send_timeout ins=%h ins_rdy got %b want 1", v, bus.ins_rdy);
      end
      step();
      bus.ins_v = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (bus.wr_v !== 1'b0) begin
         errors++; $display("FAIL reset_wr_v got %b want 0", bus.wr_v);
      end
      checks++;
      if (bus.wr_sel !== 8'h00) begin
         errors++; $display("FAIL reset_wr_sel got %h want 00", bus.wr_sel);
      end
      checks++;
      if (bus.wr_dat !== 64'h0) begin
         errors++; $display("FAIL reset_wr_dat got %h want 0", bus.wr_dat);
      end
      checks++;
      if (bus.wr_adr !== 32'h0) begin
         errors++; $display("FAIL reset_wr_adr got %h want 0", bus.wr_adr);
      end
      checks++;
      if (pc_o !== 32'h0) begin
         errors++; $display("FAIL reset_pc got %h want 0", pc_o);
      end
      rst = 1'b0;
      step();
      checks++;
      if (bus.ins_rdy !== 1'b1) begin
         errors++; $display("FAIL reset_ins_rdy got %b want 1", bus.ins_rdy);
      end
   endtask

   task automatic test_aligned();
      clear_q();
      bus.wr_rdy = 1'b1;
      load(32'h1000);
      checks++;
      if (pc_o !== 32'h1000) begin
         errors++; $display("FAIL aligned_ld_pc got %h want 00001000", pc_o);
      end
      send(48'hFFFF_13121110, 1'b0);
      send(48'hFFFF_23222120, 1'b0);
      send(48'hFFFF_33323130, 1'b0);
      send(48'hFFFF_3B3A3938, 1'b0);
      step();
      step();
      checks++;
      if (q_adr.size() !== 2) begin
         errors++; $display("FAIL aligned_count got %0d want 2", q_adr.size());
      end else begin
         checks++;
         if ({q_adr[0], q_sel[0], q_dat[0]} !== {32'h1000, 8'hFF, 64'h23222120_13121110}) begin
            errors++;
            $display("FAIL aligned_w0 got %h %h %h want 00001000 ff 2322212013121110",
                     q_adr[0], q_sel[0], q_dat[0]);
         end
         checks++;
         if ({q_adr[1], q_sel[1], q_dat[1]} !== {32'h1008, 8'hFF, 64'h3B3A3938_33323130}) begin
            errors++;
            $display("FAIL aligned_w1 got %h %h %h want 00001008 ff 3b3a393833323130",
                     q_adr[1], q_sel[1], q_dat[1]);
         end
      end
      checks++;
      if (pc_o !== 32'h1010) begin
         errors++; $display("FAIL aligned_pc got %h want 00001010", pc_o);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if (bus.wr_v !== 1'b0) begin
         errors++; $display("FAIL empty_flush_wr_v got %b want 0", bus.wr_v);
      end
      step();
      checks++;
      if (q_adr.size() !== 2) begin
         errors++; $display("FAIL empty_flush_count got %0d want 2", q_adr.size());
      end
   endtask

   task automatic test_unaligned();
      clear_q();
      load(32'h1002);
      checks++;
      if (pc_o !== 32'h1002) begin
         errors++; $display("FAIL unaligned_ld_pc got %h want 00001002", pc_o);
      end
      send(48'h5554_53525150, 1'b0);
      step();
      step();
      checks++;
      if (q_adr.size() !== 1) begin
         errors++; $display("FAIL unaligned_count got %0d want 1", q_adr.size());
      end else begin
         checks++;
         if ({q_adr[0], q_sel[0], q_dat[0][63:16]} !== {32'h1000, 8'hFC, 48'h5554_53525150}) begin
            errors++;
            $display("FAIL unaligned_w0 got %h %h %h want 00001000 fc 555453525150",
                     q_adr[0], q_sel[0], q_dat[0][63:16]);
         end
      end
      checks++;
      if (pc_o !== 32'h1008) begin
         errors++; $display("FAIL unaligned_pc got %h want 00001008", pc_o);
      end
   endtask

   task automatic test_flush_partial();
      clear_q();
      load(32'h1000);
      send(48'hFFFF_FFFF_8180, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      checks++;
      if (q_adr.size() !== 1) begin
         errors++; $display("FAIL partial_count1 got %0d want 1", q_adr.size());
      end else begin
         checks++;
         if ({q_adr[0], q_sel[0], q_dat[0][15:0]} !== {32'h1000, 8'h03, 16'h8180}) begin
            errors++;
            $display("FAIL partial_w0 got %h %h %h want 00001000 03 8180",
                     q_adr[0], q_sel[0], q_dat[0][15:0]);
         end
      end
      send(48'hFFFF_07060504, 1'b0);
      // Load with buffered bytes must be ignored.
      load(32'h5000);
      checks++;
      if (pc_o !== 32'h1006) begin
         errors++; $display("FAIL ld_ignored_pc got %h want 00001006", pc_o);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if (pc_o !== 32'h1006) begin
         errors++; $display("FAIL partial_pc got %h want 00001006", pc_o);
      end
      step();
      checks++;
      if (q_adr.size() !== 2) begin
         errors++; $display("FAIL partial_count2 got %0d want 2", q_adr.size());
      end else begin
         checks++;
         if ({q_adr[1], q_sel[1], q_dat[1][47:16]} !== {32'h1000, 8'h3C, 32'h07060504}) begin
            errors++;
            $display("FAIL partial_w1 got %h %h %h want 00001000 3c 07060504",
                     q_adr[1], q_sel[1], q_dat[1][47:16]);
         end
      end
   endtask

   task automatic test_stall();
      clear_q();
      load(32'h2000);
      bus.wr_rdy = 1'b0;
      send(48'hFFFF_13121110, 1'b0);
      send(48'hFFFF_23222120, 1'b0);
      bus.ins_v = 1'b1;
      bus.ins   = 48'hFFFF_33323130;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if ({bus.ins_rdy, bus.wr_v, bus.wr_adr, bus.wr_sel, bus.wr_dat} !==
             {1'b0, 1'b1, 32'h2000, 8'hFF, 64'h23222120_13121110}) begin
            errors++;
            $display("FAIL stall_hold%0d got rdy=%b v=%b %h %h %h want rdy=0 v=1 00002000 ff %s",
                     c, bus.ins_rdy, bus.wr_v, bus.wr_adr, bus.wr_sel, bus.wr_dat,
                     "2322212013121110");
         end
         step();
      end
      bus.wr_rdy = 1'b1;
      #1;
      checks++;
      if (bus.ins_rdy !== 1'b1) begin
         errors++; $display("FAIL stall_release_rdy got %b want 1", bus.ins_rdy);
      end
      step();
      bus.ins_v = 1'b0;
      checks++;
      if ({q_adr.size(), bus.wr_v, pc_o} !== {32'd1, 1'b0, 32'h200C}) begin
         errors++;
         $display("FAIL stall_drain got n=%0d v=%b pc=%h want n=1 v=0 pc=0000200c",
                  q_adr.size(), bus.wr_v, pc_o);
      end
   endtask

   task automatic test_stream();
      logic [47:0] prog[40];
      logic [47:0] got;
      logic [47:0] want;
      int unsigned a;
      int          total;
      int          l;
      bus.wr_rdy = 1'b1;
      flush = 1'b1;
      step();
      step();
      flush = 1'b0;
      step();
      clear_q();
      mem.delete();
      load(32'h3000);
      total = 0;
      for (int k = 0; k < 40; k++) begin
         prog[k] = {$urandom(), $urandom()};
         case (k % 3)
            0: prog[k][7:0] = 8'h40 | 8'(k);
            1: prog[k][7:0] = 8'h80 | 8'(k);
            default: prog[k][7:0] = 8'(k);
         endcase
         total += len_of(prog[k][7:0]);
         send(prog[k], 1'b1);
      end
      bus.wr_rdy = 1'b1;
      flush = 1'b1;
      step();
      step();
      flush = 1'b0;
      step();
      checks++;
      if (pc_o !== 32'h3000 + 32'(total)) begin
         errors++; $display("FAIL stream_pc got %h want %h", pc_o, 32'h3000 + 32'(total));
      end
      a = 32'h3000;
      for (int k = 0; k < 40; k++) begin
         l    = mem.exists(a) ? len_of(mem[a]) : 2;
         got  = '0;
         want = '0;
         for (int b = 0; b < 6; b++) begin
            if (b < l) got[8*b +: 8] = mem.exists(a + 32'(b)) ? mem[a + 32'(b)] : 8'hxx;
            if (b < len_of(prog[k][7:0])) want[8*b +: 8] = prog[k][8*b +: 8];
         end
         checks++;
         if (got !== want) begin
            errors++; $display("FAIL stream_ins%0d at %h got %h want %h", k, a, got, want);
         end
         a += 32'(l);
      end
   endtask

   task automatic test_dci();
      load(32'h4000);
      send({40'hFF_FFFF_FFFF, 2'b00, OP_CMPRSSD}, 1'b0);
      checks++;
`ifdef FT64_PACK_DCI_EN
      if (pc_o !== 32'h4002) begin
         errors++; $display("FAIL dci_len got %h want 00004002", pc_o);
      end
`else
      if (pc_o !== 32'h4004) begin
         errors++; $display("FAIL dci_len got %h want 00004004", pc_o);
      end
`endif
   endtask

   initial begin
      rst        = 1'b1;
      ld_adr     = 1'b0;
      flush      = 1'b0;
      start_adr  = '0;
      bus.ins_v  = 1'b0;
      bus.ins    = '0;
      bus.wr_rdy = 1'b0;
      test_reset();
      test_aligned();
      test_unaligned();
      test_flush_partial();
      test_stall();
      test_stream();
      test_dci();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
